// File: rtl/ram_2port_sync_clr.sv
// Single-clock 1R/1W RAM with byte enables, write-first forwarding, optional output
// register and a post-reset clear sequencer that zeroes every word before accepting requests.
module ram_2port_sync_clr #(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 256*6,
  parameter int OUT_REG    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   wbe,
  input  logic [31:0]               w_addr,
  input  logic [DATA_WIDTH-1:0]     wd,
  input  logic                      re,
  input  logic [31:0]               r_addr,
  output logic [DATA_WIDTH-1:0]     rd,
  output logic                      rd_valid,
  output logic                      rd_err,
  output logic                      busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state_reg;
  logic [AW-1:0]   clr_ptr_reg;
  logic            busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
      busy_reg    <= 1'b1;
    end else if (state_reg == CLEAR) begin
      if (clr_ptr_reg == AW'(LENGTH - 1)) begin
        state_reg   <= READY;
        busy_reg    <= 1'b0;
        clr_ptr_reg <= '0;
      end else begin
        clr_ptr_reg <= clr_ptr_reg + AW'(1);
      end
    end
  end

  assign busy = busy_reg;

  // Request qualification: full 32-bit range compare, no wrap.
  logic          ready_now;
  logic          clr_we;
  logic          w_hit;
  logic          r_acc;
  logic          r_hit;
  logic          same_addr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign ready_now = (state_reg == READY) && !rst;
  assign clr_we    = (state_reg == CLEAR) && !rst;
  assign w_hit     = ready_now && we && (w_addr < 32'(LENGTH));
  assign r_acc     = ready_now && re;
  assign r_hit     = r_acc && (r_addr < 32'(LENGTH));
  assign same_addr = w_hit && (w_addr == r_addr);
  assign wr_idx    = clr_we ? clr_ptr_reg : w_addr[AW-1:0];
  assign rd_idx    = r_addr[AW-1:0];

  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid_reg;
  logic                  s1_err_reg;

  // One byte-wide array per lane so each byte enable maps onto its own write strobe.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [LENGTH];
      logic [7:0] q_reg;
      logic       lane_we;
      logic [7:0] lane_wd;

      assign lane_we = clr_we || (w_hit && wbe[gi]);
      assign lane_wd = clr_we ? 8'h00 : wd[8*gi +: 8];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem[wr_idx] <= lane_wd;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= 8'h00;
        end else if (r_acc) begin
          if (!r_hit) begin
            q_reg <= 8'h00;
          end else if (same_addr && wbe[gi]) begin
            q_reg <= wd[8*gi +: 8];
          end else begin
            q_reg <= mem[rd_idx];
          end
        end
      end

      assign s1_data[8*gi +: 8] = q_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= r_acc;
      s1_err_reg   <= r_acc && !r_hit;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd_reg;
      logic                  rd_valid_reg;
      logic                  rd_err_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_reg       <= '0;
          rd_valid_reg <= 1'b0;
          rd_err_reg   <= 1'b0;
        end else begin
          rd_valid_reg <= s1_valid_reg;
          rd_err_reg   <= s1_err_reg;
          if (s1_valid_reg) begin
            rd_reg <= s1_data;
          end
        end
      end

      assign rd       = rd_reg;
      assign rd_valid = rd_valid_reg;
      assign rd_err   = rd_err_reg;
    end else begin : g_out_direct
      assign rd       = s1_data;
      assign rd_valid = s1_valid_reg;
      assign rd_err   = s1_err_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ram_2port_sync_clr.sv
// Scoreboard bench: two instances (OUT_REG=0 and 1) share one stimulus stream;
// expected read results are queued at drive time and popped when each rd_valid fires.
module tb_ram_2port_sync_clr;

  localparam int DW  = 32;
  localparam int LEN = 32;
  localparam int NB  = DW / 8;
  localparam int AW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [NB-1:0] wbe = '0;
  logic [31:0]   w_addr = '0;
  logic [DW-1:0] wd = '0;
  logic          re = 1'b0;
  logic [31:0]   r_addr = '0;

  logic [DW-1:0] rd0, rd1;
  logic          rd_valid0, rd_valid1, rd_err0, rd_err1, busy0, busy1;

  ram_2port_sync_clr #(.DATA_WIDTH(DW), .LENGTH(LEN), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .we(we), .wbe(wbe), .w_addr(w_addr), .wd(wd),
    .re(re), .r_addr(r_addr), .rd(rd0), .rd_valid(rd_valid0), .rd_err(rd_err0), .busy(busy0)
  );

  ram_2port_sync_clr #(.DATA_WIDTH(DW), .LENGTH(LEN), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .we(we), .wbe(wbe), .w_addr(w_addr), .wd(wd),
    .re(re), .r_addr(r_addr), .rd(rd1), .rd_valid(rd_valid1), .rd_err(rd_err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem_m [LEN];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor, half a cycle away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid0) begin
      if (q0.size() == 0) chk("spurious_valid0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("rd0", rd0, e.data);
        chk("rd_err0", {31'd0, rd_err0}, {31'd0, e.err});
        chk("lat0", 32'(cyc - e.cyc), 32'd0);
        $display("read0 data=%h err=%0d", rd0, rd_err0);
      end
    end
    if (rd_valid1) begin
      if (q1.size() == 0) chk("spurious_valid1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("rd1", rd1, e.data);
        chk("rd_err1", {31'd0, rd_err1}, {31'd0, e.err});
        chk("lat1", 32'(cyc - e.cyc), 32'd1);
        $display("read1 data=%h err=%0d", rd1, rd_err1);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < LEN; i++) mem_m[i] = '0;
  endtask

  // One cycle of stimulus; the model is only consulted when the DUT is accepting.
  task automatic op(input logic w, input logic [3:0] be, input logic [31:0] wa,
                    input logic [31:0] d, input logic r, input logic [31:0] ra);
    exp_t        e;
    logic [31:0] v;
    bit          rdy;
    rdy = !busy0 && !rst;
    we = w; wbe = be; w_addr = wa; wd = d; re = r; r_addr = ra;
    if (rdy && r) begin
      if (ra < LEN) begin
        v = mem_m[ra[AW-1:0]];
        if (w && wa == ra)
          for (int b = 0; b < NB; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
        e.data = v;
        e.err  = 1'b0;
      end else begin
        e.data = '0;
        e.err  = 1'b1;
      end
      e.cyc = cyc + 1;
      q0.push_back(e);
      q1.push_back(e);
    end
    if (rdy && w && wa < LEN)
      for (int b = 0; b < NB; b++) if (be[b]) mem_m[wa[AW-1:0]][8*b +: 8] = d[8*b +: 8];
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd0"}, rd0, '0);
    chk({tag, "_valid0"}, {31'd0, rd_valid0}, 32'd0);
    chk({tag, "_err0"}, {31'd0, rd_err0}, 32'd0);
    chk({tag, "_busy0"}, {31'd0, busy0}, 32'd1);
    chk({tag, "_rd1"}, rd1, '0);
    chk({tag, "_valid1"}, {31'd0, rd_valid1}, 32'd0);
    chk({tag, "_err1"}, {31'd0, rd_err1}, 32'd0);
    chk({tag, "_busy1"}, {31'd0, busy1}, 32'd1);
  endtask

  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs(tag);
    rst = 1'b0;
  endtask

  // Counts rising edges with rst low until busy drops; bounded.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (busy0 && n < 4 * LEN) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(n), 32'(LEN));
    chk({tag, "_busy1"}, {31'd0, busy1}, 32'd0);
    $display("clear %s edges=%0d", tag, n);
    model_clear();
  endtask

  initial begin
    exp_t e;
    int   wa;

    idle(3);
    chk_reset_outs("init");
    rst = 1'b0;
    wait_ready("clr_init");

    // Clear sequence wipes a written word.
    op(1, 4'hF, 5, 32'hDEADBEEF, 0, 0);
    op(0, 4'h0, 0, 0, 1, 5);
    idle(3);
    pulse_rst("rst_pulse");
    wait_ready("clr_after_pulse");
    op(0, 4'h0, 0, 0, 1, 5);

    // Byte enables.
    op(1, 4'hF, 10, 32'h11223344, 0, 0);
    op(1, 4'h5, 10, 32'hAABBCCDD, 0, 0);
    op(0, 4'h0, 0, 0, 1, 10);

    // Read-during-write, same address.
    op(1, 4'hF, 20, 32'h01020304, 0, 0);
    op(1, 4'hC, 20, 32'hA0B0C0D0, 1, 20);
    op(0, 4'h0, 0, 0, 1, 20);
    idle(2);

    // Back-to-back reads of preloaded 0..7.
    for (int a = 0; a < 8; a++) op(1, 4'hF, a, a, 0, 0);
    for (int a = 0; a < 8; a++) op(0, 4'h0, 0, 0, 1, a);
    idle(3);

    // Range checks.
    op(1, 4'hF, LEN - 1, 32'h600DF00D, 0, 0);
    op(1, 4'hF, LEN, 32'hFFFFFFFF, 0, 0);
    op(0, 4'h0, 0, 0, 1, LEN);
    op(0, 4'h0, 0, 0, 1, 32'hFFFFFFFF);
    op(0, 4'h0, 0, 0, 1, LEN - 1);
    for (int a = 0; a < LEN; a++) op(0, 4'h0, 0, 0, 1, a);

    // Random mixed traffic, biased toward same-address collisions.
    for (int i = 0; i < 150; i++) begin
      wa = $urandom_range(0, LEN + 1);
      op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa, $urandom(),
         1'($urandom_range(0, 1)),
         ($urandom_range(0, 2) == 0) ? 32'(wa) : 32'($urandom_range(0, LEN + 1)));
    end
    idle(3);

    // Reset mid-clear; requests during clear must be ignored.
    pulse_rst("rst_pre_midclr");
    for (int i = 0; i < LEN / 2; i++) op(1, 4'hF, 7, 32'hFFFFFFFF, 1, 7);
    pulse_rst("rst_midclr");
    wait_ready("clr_restart");

    // Reset one cycle after an accepted read: only the OUT_REG=0 copy has already delivered it.
    op(1, 4'hF, 3, 32'h5A5A5A5A, 0, 0);
    idle(2);
    re = 1'b1; r_addr = 3;
    e.data = 32'h5A5A5A5A; e.err = 1'b0; e.cyc = cyc + 1;
    q0.push_back(e);
    @(posedge clk); #1;
    re = 1'b0;
    pulse_rst("rst_midread");
    wait_ready("clr_midread");
    op(0, 4'h0, 0, 0, 1, 3);
    idle(4);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
